// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall synchronizer/debounce, sector decode,
// per-phase OFF/DEAD/HIGH/LOW gate FSMs with dead-time and sticky fault.
module bldc_commutator #(
    parameter int DEADTIME = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       EN,
    input  logic       PWM,
    input  logic       DIR,
    input  logic [2:0] HALL,
    output logic       AH,
    output logic       AL,
    output logic       BH,
    output logic       BL,
    output logic       CH,
    output logic       CL,
    output logic [2:0] SECTOR,
    output logic       FAULT
);

    localparam int DW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int CW = (DEADTIME < 2) ? 1 : $clog2(DEADTIME);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEADTIME - 1);

    typedef enum logic [1:0] {
        PH_OFF,
        PH_DEAD,
        PH_HIGH,
        PH_LOW
    } ph_state_e;

    logic [2:0]    hall_meta_q, hall_meta_d;
    logic [2:0]    hall_sync_q, hall_sync_d;
    logic [2:0]    cand_q, cand_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]    acc_q, acc_d;
    logic [2:0]    sector_q, sector_d;
    logic          seen_q, seen_d;
    logic          fault_q, fault_d;

    logic          acc_valid;
    logic [2:0]    acc_sector;

    // Phase vectors are ordered {A, B, C}
    logic [2:0]    hi_sel, lo_sel;
    logic [2:0]    req_hi, req_lo;
    logic          force_off;

    ph_state_e     ph_state_q [3];
    ph_state_e     ph_state_d [3];
    logic [CW-1:0] ph_cnt_q [3];
    logic [CW-1:0] ph_cnt_d [3];
    logic          ph_tgt_hi_q [3];
    logic          ph_tgt_hi_d [3];

    function automatic logic [3:0] hall_decode(input logic [2:0] h);
        logic [3:0] r;
        r = 4'b0000;
        unique case (h)
            3'b101:  r = {1'b1, 3'd0};
            3'b100:  r = {1'b1, 3'd1};
            3'b110:  r = {1'b1, 3'd2};
            3'b010:  r = {1'b1, 3'd3};
            3'b011:  r = {1'b1, 3'd4};
            3'b001:  r = {1'b1, 3'd5};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    always_comb begin
        hall_meta_d = HALL;
        hall_sync_d = hall_meta_q;
        cand_d      = cand_q;
        db_cnt_d    = db_cnt_q;
        acc_d       = acc_q;
        sector_d    = sector_q;
        seen_d      = seen_q;
        fault_d     = fault_q;
        acc_valid   = 1'b0;
        acc_sector  = 3'd0;
        if (CE) begin
            if (hall_sync_q != cand_q) begin
                cand_d   = hall_sync_q;
                db_cnt_d = DW'(1);
            end else if (db_cnt_q != DB_MAX) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            if (db_cnt_d == DB_MAX) begin
                acc_d = cand_d;
            end
            {acc_valid, acc_sector} = hall_decode(acc_d);
            if (acc_valid) begin
                sector_d = acc_sector;
                seen_d   = 1'b1;
            end
            if (!EN) begin
                fault_d = 1'b0;
            end else if (seen_q && !acc_valid) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hall_meta_q <= 3'b000;
            hall_sync_q <= 3'b000;
        end else begin
            hall_meta_q <= hall_meta_d;
            hall_sync_q <= hall_sync_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cand_q   <= 3'b000;
            db_cnt_q <= '0;
            acc_q    <= 3'b000;
            sector_q <= 3'd0;
            seen_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
            acc_q    <= acc_d;
            sector_q <= sector_d;
            seen_q   <= seen_d;
            fault_q  <= fault_d;
        end
    end

    // Requests come from the registered sector, so a sector change and a
    // PWM edge landing together are both seen against the new sector.
    always_comb begin
        hi_sel = 3'b000;
        lo_sel = 3'b000;
        unique case (sector_q)
            3'd0:    begin hi_sel = 3'b100; lo_sel = 3'b010; end
            3'd1:    begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'd2:    begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'd3:    begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'd4:    begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'd5:    begin hi_sel = 3'b001; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
        if (DIR) begin
            {hi_sel, lo_sel} = {lo_sel, hi_sel};
        end
        req_hi    = seen_q ? (hi_sel & {3{PWM}}) : 3'b000;
        req_lo    = seen_q ? lo_sel : 3'b000;
        force_off = !EN || fault_q;
    end

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            ph_state_d[p]  = ph_state_q[p];
            ph_cnt_d[p]    = ph_cnt_q[p];
            ph_tgt_hi_d[p] = ph_tgt_hi_q[p];
            if (CE) begin
                if (force_off) begin
                    ph_state_d[p] = PH_OFF;
                    ph_cnt_d[p]   = '0;
                end else begin
                    unique case (ph_state_q[p])
                        PH_OFF: begin
                            if (req_hi[p] || req_lo[p]) begin
                                ph_state_d[p]  = PH_DEAD;
                                ph_cnt_d[p]    = '0;
                                ph_tgt_hi_d[p] = req_hi[p];
                            end
                        end
                        PH_DEAD: begin
                            if (!req_hi[p] && !req_lo[p]) begin
                                ph_state_d[p] = PH_OFF;
                                ph_cnt_d[p]   = '0;
                            end else if (req_hi[p] != ph_tgt_hi_q[p]) begin
                                ph_cnt_d[p]    = '0;
                                ph_tgt_hi_d[p] = req_hi[p];
                            end else if (ph_cnt_q[p] == CNT_LAST) begin
                                ph_state_d[p] = ph_tgt_hi_q[p] ? PH_HIGH : PH_LOW;
                                ph_cnt_d[p]   = '0;
                            end else begin
                                ph_cnt_d[p] = ph_cnt_q[p] + 1'b1;
                            end
                        end
                        PH_HIGH: begin
                            if (!req_hi[p]) begin
                                ph_state_d[p]  = req_lo[p] ? PH_DEAD : PH_OFF;
                                ph_cnt_d[p]    = '0;
                                ph_tgt_hi_d[p] = 1'b0;
                            end
                        end
                        PH_LOW: begin
                            if (!req_lo[p]) begin
                                ph_state_d[p]  = req_hi[p] ? PH_DEAD : PH_OFF;
                                ph_cnt_d[p]    = '0;
                                ph_tgt_hi_d[p] = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int p = 0; p < 3; p++) begin
            if (!RST_N) begin
                ph_state_q[p]  <= PH_OFF;
                ph_cnt_q[p]    <= '0;
                ph_tgt_hi_q[p] <= 1'b0;
            end else begin
                ph_state_q[p]  <= ph_state_d[p];
                ph_cnt_q[p]    <= ph_cnt_d[p];
                ph_tgt_hi_q[p] <= ph_tgt_hi_d[p];
            end
        end
    end

    assign AH     = (ph_state_q[2] == PH_HIGH);
    assign AL     = (ph_state_q[2] == PH_LOW);
    assign BH     = (ph_state_q[1] == PH_HIGH);
    assign BL     = (ph_state_q[1] == PH_LOW);
    assign CH     = (ph_state_q[0] == PH_HIGH);
    assign CL     = (ph_state_q[0] == PH_LOW);
    assign SECTOR = sector_q;
    assign FAULT  = fault_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator with overlap/dead-time monitors
// and a randomized stress phase.
module tb_bldc_commutator;

    localparam int DT = 8;

    logic       CLK;
    logic       RST_N;
    logic       CE;
    logic       EN;
    logic       PWM;
    logic       DIR;
    logic [2:0] HALL;
    logic       AH, AL, BH, BL, CH, CL;
    logic [2:0] SECTOR;
    logic       FAULT;
    logic [5:0] gates;

    int total;
    int bad;

    bldc_commutator #(
        .DEADTIME(DT),
        .DEBOUNCE(4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE    (CE),
        .EN    (EN),
        .PWM   (PWM),
        .DIR   (DIR),
        .HALL  (HALL),
        .AH    (AH),
        .AL    (AL),
        .BH    (BH),
        .BL    (BL),
        .CH    (CH),
        .CL    (CL),
        .SECTOR(SECTOR),
        .FAULT (FAULT)
    );

    assign gates = {AH, AL, BH, BL, CH, CL};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitors: no high/low overlap, and every gate turn-on preceded by
    // at least DT clock-enabled edges with both gates of that phase low.
    logic [5:0] pre_g;
    logic       ce_p;
    logic       rst_p;
    int         off_cnt [3];

    always @(posedge CLK) begin
        pre_g = gates;
        ce_p  = CE;
        rst_p = RST_N;
    end

    always @(negedge CLK) begin
        total++;
        assert (!((AH === 1'b1 && AL === 1'b1) ||
                  (BH === 1'b1 && BL === 1'b1) ||
                  (CH === 1'b1 && CL === 1'b1)))
        else begin
            bad++;
            $error("FAIL overlap observed=%b expected=no xH&xL", gates);
        end
        for (int p = 0; p < 3; p++) begin
            if (rst_p !== 1'b1) begin
                off_cnt[p] = 0;
            end else if (ce_p === 1'b1) begin
                if (pre_g[5-2*p] === 1'b0 && pre_g[4-2*p] === 1'b0)
                    off_cnt[p]++;
                else
                    off_cnt[p] = 0;
                if ((gates[5-2*p] === 1'b1 && pre_g[5-2*p] !== 1'b1) ||
                    (gates[4-2*p] === 1'b1 && pre_g[4-2*p] !== 1'b1)) begin
                    total++;
                    assert (off_cnt[p] >= DT)
                    else begin
                        bad++;
                        $error("FAIL deadtime phase=%0d observed=%0d expected>=%0d",
                               p, off_cnt[p], DT);
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] h;
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        EN    = 1'b1;
        CE    = 1'b1;
        PWM   = 1'b1;
        DIR   = 1'b0;
        HALL  = 3'b101;
        tick(2);
        chk("rst_gates", 8'(gates), 8'h00);
        chk("rst_sector", 8'(SECTOR), 8'd0);
        chk("rst_fault", 8'(FAULT), 8'd0);
        RST_N = 1'b1;

        // startup: 2 sync + 4 debounce, then 8-cycle DEAD
        tick(14);
        chk("start_e14", 8'(gates), 8'b000000);
        tick(1);
        chk("start_e15", 8'(gates), 8'b100100);
        chk("start_sec", 8'(SECTOR), 8'd0);

        // sector 0 -> 1
        HALL = 3'b100;
        tick(5);
        chk("s1_e20_sec", 8'(SECTOR), 8'd0);
        chk("s1_e20", 8'(gates), 8'b100100);
        tick(1);
        chk("s1_e21_sec", 8'(SECTOR), 8'd1);
        chk("s1_e21", 8'(gates), 8'b100100);
        tick(1);
        chk("s1_e22", 8'(gates), 8'b100000);
        tick(7);
        chk("s1_e29", 8'(gates), 8'b100000);
        tick(1);
        chk("s1_e30", 8'(gates), 8'b100001);

        // 3-cycle glitch is rejected
        HALL = 3'b110;
        tick(3);
        HALL = 3'b100;
        tick(3);
        chk("gl_e36_sec", 8'(SECTOR), 8'd1);
        chk("gl_e36", 8'(gates), 8'b100001);
        tick(4);
        chk("gl_e40_sec", 8'(SECTOR), 8'd1);
        chk("gl_e40", 8'(gates), 8'b100001);

        // direction reversal in sector 1: A+C- becomes C+A-
        DIR = 1'b1;
        tick(1);
        chk("dir_e41", 8'(gates), 8'b000000);
        tick(7);
        chk("dir_e48", 8'(gates), 8'b000000);
        tick(1);
        chk("dir_e49", 8'(gates), 8'b010010);

        // PWM low floats the high side, restart via DEAD
        PWM = 1'b0;
        tick(1);
        chk("pwm_off", 8'(gates), 8'b010000);
        PWM = 1'b1;
        tick(8);
        chk("pwm_dead", 8'(gates), 8'b010000);
        tick(1);
        chk("pwm_on", 8'(gates), 8'b010010);

        // invalid hall -> fault
        HALL = 3'b111;
        tick(5);
        chk("flt_e64", 8'(FAULT), 8'd0);
        chk("flt_e64_g", 8'(gates), 8'b010010);
        tick(1);
        chk("flt_e65", 8'(FAULT), 8'd1);
        chk("flt_e65_sec", 8'(SECTOR), 8'd1);
        chk("flt_e65_g", 8'(gates), 8'b010010);
        tick(1);
        chk("flt_e66_g", 8'(gates), 8'b000000);
        chk("flt_e66", 8'(FAULT), 8'd1);

        // EN low clears fault; re-enable after valid halls settle
        EN   = 1'b0;
        HALL = 3'b100;
        tick(1);
        chk("en0_fault", 8'(FAULT), 8'd0);
        chk("en0_g", 8'(gates), 8'b000000);
        tick(5);
        chk("en0_e72_sec", 8'(SECTOR), 8'd1);
        chk("en0_e72_f", 8'(FAULT), 8'd0);
        chk("en0_e72_g", 8'(gates), 8'b000000);
        EN = 1'b1;
        tick(8);
        chk("en1_e80", 8'(gates), 8'b000000);
        tick(1);
        chk("en1_e81", 8'(gates), 8'b010010);
        chk("en1_fault", 8'(FAULT), 8'd0);

        // CE low freezes debounce and phases
        CE   = 1'b0;
        HALL = 3'b110;
        tick(10);
        chk("ce0_sec", 8'(SECTOR), 8'd1);
        chk("ce0_g", 8'(gates), 8'b010010);
        CE = 1'b1;
        tick(3);
        chk("ce1_e94_sec", 8'(SECTOR), 8'd1);
        tick(1);
        chk("ce1_e95_sec", 8'(SECTOR), 8'd2);
        tick(1);
        chk("ce1_e96", 8'(gates), 8'b000010);
        tick(8);
        chk("ce1_e104", 8'(gates), 8'b000110);

        // reset while driving: no dead-time carried over
        RST_N = 1'b0;
        tick(1);
        chk("rst2_g", 8'(gates), 8'b000000);
        chk("rst2_sec", 8'(SECTOR), 8'd0);
        chk("rst2_f", 8'(FAULT), 8'd0);
        RST_N = 1'b1;
        tick(14);
        chk("rst2_e14", 8'(gates), 8'b000000);
        tick(1);
        chk("rst2_e15", 8'(gates), 8'b000110);
        chk("rst2_sec2", 8'(SECTOR), 8'd2);

        // randomized stress, checked by the monitors
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                h = 3'($urandom_range(0, 7));
                if ((h == 3'b000 || h == 3'b111) && $urandom_range(0, 9) != 0)
                    h = 3'b101;
                HALL = h;
            end
            PWM   = ($urandom_range(0, 31) != 0);
            CE    = ($urandom_range(0, 7) != 0);
            EN    = ($urandom_range(0, 499) != 0);
            RST_N = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 199) == 0)
                DIR = ~DIR;
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
